// File: rtl/romulus_pdo_serializer.sv
// Output stage for the Romulus-N x4 core: buffers 32-bit pdo words in a small FIFO
// and serializes each word MSB-first onto a byte-wide host port.
module romulus_pdo_serializer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic [31:0]              in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [31:0]              byte_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    logic [31:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r, wr_ptr_s;
    logic [AW-1:0] rd_ptr_r, rd_ptr_s;
    logic [AW:0]   level_r, level_s;
    state_t        state_r, state_s;
    logic [31:0]   shift_r, shift_s;
    logic [1:0]    idx_r, idx_s;
    logic [31:0]   byte_count_r, byte_count_s;
    logic          out_valid_r, out_valid_s;
    logic          in_ready_r, in_ready_s;
    logic          wr_s;
    logic          pop_s;

    // Next-state decode for FIFO pointers, occupancy and the serializer FSM.
    always_comb begin
        wr_s         = in_valid && in_ready_r;
        pop_s        = 1'b0;
        state_s      = state_r;
        shift_s      = shift_r;
        idx_s        = idx_r;
        byte_count_s = byte_count_r;
        wr_ptr_s     = wr_ptr_r;
        rd_ptr_s     = rd_ptr_r;
        level_s      = level_r;

        case (state_r)
            IDLE: begin
                if (level_r != '0) begin
                    pop_s   = 1'b1;
                    shift_s = mem_r[rd_ptr_r];
                    idx_s   = 2'd0;
                    state_s = BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (out_ready) begin
                    byte_count_s = byte_count_r + 32'd1;
                    if (idx_r != 2'd3) begin
                        shift_s = {shift_r[23:0], 8'h00};
                        idx_s   = idx_r + 2'd1;
                    end else if (level_r != '0) begin
                        // Back-to-back reload keeps the byte stream free of bubbles.
                        pop_s   = 1'b1;
                        shift_s = mem_r[rd_ptr_r];
                        idx_s   = 2'd0;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = BUSY;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        if (wr_s) begin
            wr_ptr_s = wr_ptr_r + AW'(1);
        end else begin
            wr_ptr_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_s = rd_ptr_r + AW'(1);
        end else begin
            rd_ptr_s = rd_ptr_r;
        end

        case ({wr_s, pop_s})
            2'b10:   level_s = level_r + (AW+1)'(1);
            2'b01:   level_s = level_r - (AW+1)'(1);
            default: level_s = level_r;
        endcase

        // Flush dominates every other event in the same cycle.
        if (clr) begin
            pop_s        = 1'b0;
            state_s      = IDLE;
            shift_s      = 32'h0000_0000;
            idx_s        = 2'd0;
            byte_count_s = 32'd0;
            wr_ptr_s     = '0;
            rd_ptr_s     = '0;
            level_s      = '0;
        end else begin
            pop_s        = pop_s;
        end

        in_ready_s  = (level_s != FULL_LEVEL);
        out_valid_s = (state_s == BUSY);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            shift_r      <= 32'h0000_0000;
            idx_r        <= 2'd0;
            byte_count_r <= 32'd0;
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            level_r      <= '0;
            out_valid_r  <= 1'b0;
            in_ready_r   <= 1'b1;
        end else begin
            state_r      <= state_s;
            shift_r      <= shift_s;
            idx_r        <= idx_s;
            byte_count_r <= byte_count_s;
            wr_ptr_r     <= wr_ptr_s;
            rd_ptr_r     <= rd_ptr_s;
            level_r      <= level_s;
            out_valid_r  <= out_valid_s;
            in_ready_r   <= in_ready_s;
        end
    end

    // FIFO storage; contents are don't-care while the occupancy is zero.
    always_ff @(posedge clk) begin
        if (wr_s && !clr) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_data   = shift_r[31:24];
    assign level      = level_r;
    assign byte_count = byte_count_r;

endmodule

// File: tb/tb_romulus_pdo_serializer.sv
// Self-checking bench for romulus_pdo_serializer: vector table, directed corner
// sequences and a randomized run scored against a byte-queue reference model.
module tb_romulus_pdo_serializer;

    logic        clk;
    logic        rst;
    logic        clr;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  level;
    logic [31:0] byte_count;

    int checks = 0;
    int errors = 0;

    romulus_pdo_serializer #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .level      (level),
        .byte_count (byte_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        clr;
        logic        in_valid;
        logic [31:0] in_data;
        logic        out_ready;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic [2:0]  exp_level;
        logic        exp_in_ready;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        clr = 1'b0;
    endtask

    // Holds out_ready high and expects the four bytes of w, MSB first.
    task automatic expect_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) begin
            int n = 0;
            out_ready = 1'b1;
            while (!out_valid && n < 20) begin
                tick();
                n++;
            end
            chk("byte_valid", out_valid, 1'b1);
            chk("byte_data", out_data, w[31-8*b -: 8]);
            tick();
        end
    endtask

    logic [31:0] wq[5];
    logic [7:0]  exp_q[$];

    initial begin
        rst = 1'b0; clr = 1'b0; in_data = 32'd0; in_valid = 1'b0; out_ready = 1'b0;
        #12;
        rst = 1'b1;

        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_level", level, 3'd0);
        chk("rst_byte_count", byte_count, 32'd0);
        chk("rst_in_ready", in_ready, 1'b1);

        // Single word A1B2C3D4 with out_ready high.
        vecs[0] = '{1'b0, 1'b1, 32'hA1B2C3D4, 1'b1, 1'b0, 8'h00, 3'd1, 1'b1, 32'd0};
        vecs[1] = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 8'hA1, 3'd0, 1'b1, 32'd0};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 8'hB2, 3'd0, 1'b1, 32'd1};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 8'hC3, 3'd0, 1'b1, 32'd2};
        vecs[4] = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 8'hD4, 3'd0, 1'b1, 32'd3};
        vecs[5] = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 32'd4};
        for (int i = 0; i < 6; i++) begin
            clr = vecs[i].clr; in_valid = vecs[i].in_valid;
            in_data = vecs[i].in_data; out_ready = vecs[i].out_ready;
            tick();
            chk("vec_out_valid", out_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                chk("vec_out_data", out_data, vecs[i].exp_data);
            end
            chk("vec_level", level, vecs[i].exp_level);
            chk("vec_in_ready", in_ready, vecs[i].exp_in_ready);
            chk("vec_byte_count", byte_count, vecs[i].exp_cnt);
        end

        // Five back-to-back words with the consumer stalled.
        do_clr();
        for (int i = 0; i < 5; i++) wq[i] = $urandom;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("fill_in_ready", in_ready, 1'b1);
            in_valid = 1'b1; in_data = wq[i];
            tick();
        end
        chk("full_in_ready", in_ready, 1'b0);
        chk("full_level", level, 3'd4);
        chk("full_out_valid", out_valid, 1'b1);
        chk("full_out_data", out_data, wq[0][31:24]);
        in_data = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_level", level, 3'd4);
            chk("stall_out_data", out_data, wq[0][31:24]);
            chk("stall_out_valid", out_valid, 1'b1);
        end
        in_valid = 1'b0;

        // Drain: 20 contiguous bytes.
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            chk("drain_valid", out_valid, 1'b1);
            chk("drain_data", out_data, wq[i/4][31-8*(i%4) -: 8]);
            tick();
        end
        chk("drain_end_valid", out_valid, 1'b0);
        chk("drain_byte_count", byte_count, 32'd20);
        chk("drain_level", level, 3'd0);

        // Randomized traffic against the byte-queue model.
        do_clr();
        begin
            int sent = 0;
            int got = 0;
            int cyc = 0;
            logic [31:0] w;
            logic took;
            w = $urandom;
            exp_q.delete();
            while (got < 400 && cyc < 5000) begin
                in_valid = (sent < 100);
                in_data = w;
                out_ready = 1'($urandom_range(0, 1));
                took = in_valid && in_ready;
                if (took) begin
                    for (int b = 0; b < 4; b++) exp_q.push_back(w[31-8*b -: 8]);
                    sent++;
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("rand_unexpected_byte", 32'd1, 32'd0);
                    end else begin
                        chk("rand_byte", out_data, exp_q.pop_front());
                    end
                    got++;
                end
                if (level == 3'd4) begin
                    chk("rand_in_ready_full", in_ready, 1'b0);
                end
                tick();
                cyc++;
                if (took) w = $urandom;
            end
            in_valid = 1'b0; out_ready = 1'b0;
            chk("rand_bytes_received", got, 32'd400);
            chk("rand_words_sent", sent, 32'd100);
            chk("rand_byte_count", byte_count, 32'd400);
            chk("rand_queue_empty", exp_q.size(), 32'd0);
        end

        // Flush mid-word with two words queued.
        do_clr();
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h11223344; tick();
        in_data = 32'hAAAA0001; tick();
        in_data = 32'hAAAA0002; tick();
        in_valid = 1'b0; out_ready = 1'b1;
        chk("clr_pre_level", level, 3'd2);
        chk("clr_byte0", out_data, 8'h11);
        tick();
        chk("clr_byte1", out_data, 8'h22);
        tick();
        chk("clr_pre_count", byte_count, 32'd2);
        clr = 1'b1; in_valid = 1'b1; in_data = 32'h99999999;
        tick();
        clr = 1'b0; in_valid = 1'b0;
        chk("clr_out_valid", out_valid, 1'b0);
        chk("clr_level", level, 3'd0);
        chk("clr_byte_count", byte_count, 32'd0);
        tick();
        chk("clr_idle_valid", out_valid, 1'b0);
        chk("clr_idle_level", level, 3'd0);
        in_valid = 1'b1; in_data = 32'h55667788; tick();
        in_valid = 1'b0;
        expect_word(32'h55667788);
        chk("clr_after_valid", out_valid, 1'b0);
        chk("clr_after_count", byte_count, 32'd4);

        // Asynchronous reset mid-stream.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hCAFEF00D; tick();
        in_data = 32'h12345678; tick();
        in_valid = 1'b0; out_ready = 1'b1; tick();
        out_ready = 1'b0;
        chk("arst_pre_valid", out_valid, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_level", level, 3'd0);
        chk("arst_byte_count", byte_count, 32'd0);
        #1;
        rst = 1'b1;
        tick();
        chk("arst_idle_valid", out_valid, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        in_valid = 1'b1; in_data = 32'h0BADBEEF; tick();
        in_valid = 1'b0;
        expect_word(32'h0BADBEEF);
        chk("arst_after_count", byte_count, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
